// File: rtl/am_pkg.sv
// Shared types and constants for the 40GBASE-R TX alignment-marker slot scheduler.
package am_pkg;

    localparam int unsigned AM_PERIOD_DEFAULT = 16384;
    localparam int unsigned AM_PERIOD_SHORT   = 64;

    typedef enum logic [1:0] {
        DIS,
        MARK,
        RUN
    } am_sched_state_t;

endpackage

// File: rtl/am_tx_sched_if.sv
// Handshake bundle between the upstream encoder/scrambler side and the AM slot scheduler.
interface am_tx_sched_if #(
    parameter int unsigned CNT_W = 14
) ();

    logic             en_i;
    logic             valid_i;
    logic             ready_o;
    logic             marker_v_o;
    logic             bip_clr_o;
    logic [CNT_W-1:0] slot_cnt_o;

    // Upstream side: enables insertion and reports slot consumption.
    modport master (
        output en_i,
        output valid_i,
        input  ready_o,
        input  marker_v_o,
        input  bip_clr_o,
        input  slot_cnt_o
    );

    // Scheduler side.
    modport slave (
        input  en_i,
        input  valid_i,
        output ready_o,
        output marker_v_o,
        output bip_clr_o,
        output slot_cnt_o
    );

endinterface

// File: rtl/am_tx_sched.sv
// Alignment-marker slot scheduler: one marker slot every period, BIP clear after each marker.
// Build option AM_TX_SHORT_PERIOD_EN forces a 64-slot period for fast simulation.
module am_tx_sched
    import am_pkg::*;
#(
    parameter int unsigned AM_PERIOD = AM_PERIOD_DEFAULT,
    parameter int unsigned CNT_W     = $clog2(AM_PERIOD)
) (
    input  logic        clk,
    input  logic        nreset,
    am_tx_sched_if.slave bus
);

`ifdef AM_TX_SHORT_PERIOD_EN
    localparam int unsigned EFF_PERIOD = AM_PERIOD_SHORT;
`else
    localparam int unsigned EFF_PERIOD = AM_PERIOD;
`endif

    // Index of the last data slot; the period wraps by entering MARK, never by overflow.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EFF_PERIOD - 2);

    am_sched_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bip_clr_q, bip_clr_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bip_clr_d = 1'b0;
        unique case (state_q)
            DIS: begin
                cnt_d = '0;
                if (bus.en_i) begin
                    state_d = MARK;
                end
            end
            MARK: begin
                // A started marker always completes, even if en_i has dropped.
                if (bus.valid_i) begin
                    cnt_d     = '0;
                    bip_clr_d = 1'b1;
                    state_d   = bus.en_i ? RUN : DIS;
                end
            end
            RUN: begin
                if (!bus.en_i) begin
                    state_d = DIS;
                    cnt_d   = '0;
                end else if (bus.valid_i) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = MARK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = DIS;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= DIS;
            cnt_q     <= '0;
            bip_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bip_clr_q <= bip_clr_d;
        end
    end

    // Decoded straight from the state register so no input reaches these outputs.
    assign bus.marker_v_o = (state_q == MARK);
    assign bus.ready_o    = (state_q != MARK);
    assign bus.bip_clr_o  = bip_clr_q;
    assign bus.slot_cnt_o = cnt_q;

endmodule

// File: tb/tb_am_tx_sched.sv
// Directed bench for am_tx_sched: a full-size instance and a 64-slot instance on one clock.
module tb_am_tx_sched;

`ifdef AM_TX_SHORT_PERIOD_EN
    localparam int EFF_L = 64;
`else
    localparam int EFF_L = 16384;
`endif
    localparam int EFF_S   = 64;
    localparam int DROP_AT = (EFF_L > 200) ? 100 : EFF_L / 2;

    logic clk;
    logic nreset;
    int   passed;
    int   total;

    am_tx_sched_if #(.CNT_W(14)) bus_l ();
    am_tx_sched_if #(.CNT_W(6))  bus_s ();

    am_tx_sched #(.AM_PERIOD(16384), .CNT_W(14)) u_dut_l (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_l)
    );

    am_tx_sched #(.AM_PERIOD(64), .CNT_W(6)) u_dut_s (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drain_l();
        bus_l.en_i    = 1'b0;
        bus_l.valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus_l.valid_i = 1'b0;
    endtask

    task automatic drain_s();
        bus_s.en_i    = 1'b0;
        bus_s.valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus_s.valid_i = 1'b0;
    endtask

    task automatic test_reset();
        nreset        = 1'b0;
        bus_l.en_i    = 1'b0;
        bus_l.valid_i = 1'b0;
        bus_s.en_i    = 1'b0;
        bus_s.valid_i = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus_l.marker_v_o !== 1'b0) $display("FAIL reset_marker_l got=%b exp=0", bus_l.marker_v_o); else passed++;
        total++; if (bus_l.ready_o !== 1'b1) $display("FAIL reset_ready_l got=%b exp=1", bus_l.ready_o); else passed++;
        total++; if (bus_l.bip_clr_o !== 1'b0) $display("FAIL reset_bip_l got=%b exp=0", bus_l.bip_clr_o); else passed++;
        total++; if (bus_l.slot_cnt_o !== 14'd0) $display("FAIL reset_cnt_l got=%0d exp=0", bus_l.slot_cnt_o); else passed++;
        total++; if (bus_s.marker_v_o !== 1'b0) $display("FAIL reset_marker_s got=%b exp=0", bus_s.marker_v_o); else passed++;
        total++; if (bus_s.ready_o !== 1'b1) $display("FAIL reset_ready_s got=%b exp=1", bus_s.ready_o); else passed++;
        total++; if (bus_s.bip_clr_o !== 1'b0) $display("FAIL reset_bip_s got=%b exp=0", bus_s.bip_clr_o); else passed++;
        total++; if (bus_s.slot_cnt_o !== 6'd0) $display("FAIL reset_cnt_s got=%0d exp=0", bus_s.slot_cnt_o); else passed++;
        nreset = 1'b1;
    endtask

    task automatic test_full_period();
        int gap = 0;
        int ready_n = 0;
        int bip_n = 0;
        int max_cnt = 0;
        bus_l.en_i    = 1'b1;
        bus_l.valid_i = 1'b1;
        @(negedge clk);
        total++; if (bus_l.marker_v_o !== 1'b1) $display("FAIL first_marker got=%b exp=1", bus_l.marker_v_o); else passed++;
        total++; if (bus_l.ready_o !== 1'b0) $display("FAIL first_marker_ready got=%b exp=0", bus_l.ready_o); else passed++;
        for (int k = 1; k <= EFF_L + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++; if (bus_l.bip_clr_o !== 1'b1) $display("FAIL bip_after_marker got=%b exp=1", bus_l.bip_clr_o); else passed++;
                total++; if (bus_l.slot_cnt_o !== 14'd0) $display("FAIL first_data_cnt got=%0d exp=0", bus_l.slot_cnt_o); else passed++;
            end
            if (bus_l.marker_v_o === 1'b1) begin
                gap = k;
                break;
            end
            if (bus_l.ready_o === 1'b1) ready_n++;
            if (bus_l.bip_clr_o === 1'b1) bip_n++;
            if (int'(bus_l.slot_cnt_o) > max_cnt) max_cnt = int'(bus_l.slot_cnt_o);
        end
        total++; if (gap != EFF_L) $display("FAIL marker_gap got=%0d exp=%0d", gap, EFF_L); else passed++;
        total++; if (ready_n != EFF_L - 1) $display("FAIL ready_slots got=%0d exp=%0d", ready_n, EFF_L - 1); else passed++;
        total++; if (bip_n != 1) $display("FAIL bip_count_period got=%0d exp=1", bip_n); else passed++;
        total++; if (max_cnt != EFF_L - 2) $display("FAIL max_cnt got=%0d exp=%0d", max_cnt, EFF_L - 2); else passed++;
        drain_l();
    endtask

    task automatic test_valid_toggle();
        int consumed = 0;
        int mark_cyc = -1;
        int hold_err = 0;
        logic ph = 1'b1;
        logic prev_v = 1'b1;
        int prev_cnt = 0;
        bus_l.en_i    = 1'b1;
        bus_l.valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus_l.marker_v_o !== 1'b1) $display("FAIL mark_persist got=%b exp=1", bus_l.marker_v_o); else passed++;
        bus_l.valid_i = 1'b1;
        @(negedge clk);
        total++; if (bus_l.bip_clr_o !== 1'b1) $display("FAIL toggle_bip got=%b exp=1", bus_l.bip_clr_o); else passed++;
        for (int c = 0; c < 2 * EFF_L + 10; c++) begin
            if (c > 0) @(negedge clk);
            if (bus_l.marker_v_o === 1'b1) begin
                mark_cyc = c;
                break;
            end
            if (!prev_v && int'(bus_l.slot_cnt_o) != prev_cnt) hold_err++;
            bus_l.valid_i = ph;
            if (ph) consumed++;
            prev_v   = ph;
            prev_cnt = int'(bus_l.slot_cnt_o);
            ph       = ~ph;
        end
        total++; if (consumed != EFF_L - 1) $display("FAIL toggle_consumed got=%0d exp=%0d", consumed, EFF_L - 1); else passed++;
        total++; if (mark_cyc != 2 * EFF_L - 3) $display("FAIL toggle_marker_cycle got=%0d exp=%0d", mark_cyc, 2 * EFF_L - 3); else passed++;
        total++; if (hold_err != 0) $display("FAIL cnt_hold_errors got=%0d exp=0", hold_err); else passed++;
        drain_l();
    endtask

    task automatic test_en_drop_run();
        logic found = 1'b0;
        bus_l.en_i    = 1'b1;
        bus_l.valid_i = 1'b1;
        for (int c = 0; c < DROP_AT + 20; c++) begin
            @(negedge clk);
            if (bus_l.marker_v_o === 1'b0 && int'(bus_l.slot_cnt_o) == DROP_AT) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) $display("FAIL reach_drop_cnt got=0 exp=1"); else passed++;
        bus_l.en_i = 1'b0;
        @(negedge clk);
        total++; if (bus_l.marker_v_o !== 1'b0) $display("FAIL drop_run_marker got=%b exp=0", bus_l.marker_v_o); else passed++;
        total++; if (bus_l.ready_o !== 1'b1) $display("FAIL drop_run_ready got=%b exp=1", bus_l.ready_o); else passed++;
        total++; if (bus_l.slot_cnt_o !== 14'd0) $display("FAIL drop_run_cnt got=%0d exp=0", bus_l.slot_cnt_o); else passed++;
        repeat (3) @(negedge clk);
        total++; if (bus_l.slot_cnt_o !== 14'd0) $display("FAIL dis_ignores_valid got=%0d exp=0", bus_l.slot_cnt_o); else passed++;
        total++; if (bus_l.marker_v_o !== 1'b0) $display("FAIL dis_no_marker got=%b exp=0", bus_l.marker_v_o); else passed++;
        bus_l.en_i = 1'b1;
        @(negedge clk);
        total++; if (bus_l.marker_v_o !== 1'b1) $display("FAIL reenable_marker got=%b exp=1", bus_l.marker_v_o); else passed++;
        drain_l();
    endtask

    task automatic test_en_drop_mark();
        bus_l.en_i    = 1'b1;
        bus_l.valid_i = 1'b0;
        @(negedge clk);
        bus_l.en_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (bus_l.marker_v_o !== 1'b1) $display("FAIL mark_held_%0d got=%b exp=1", c, bus_l.marker_v_o); else passed++;
        end
        total++; if (bus_l.bip_clr_o !== 1'b0) $display("FAIL bip_during_mark got=%b exp=0", bus_l.bip_clr_o); else passed++;
        bus_l.valid_i = 1'b1;
        @(negedge clk);
        total++; if (bus_l.bip_clr_o !== 1'b1) $display("FAIL drop_mark_bip got=%b exp=1", bus_l.bip_clr_o); else passed++;
        total++; if (bus_l.marker_v_o !== 1'b0) $display("FAIL drop_mark_done got=%b exp=0", bus_l.marker_v_o); else passed++;
        @(negedge clk);
        total++; if (bus_l.bip_clr_o !== 1'b0) $display("FAIL bip_one_cycle got=%b exp=0", bus_l.bip_clr_o); else passed++;
        total++; if (bus_l.marker_v_o !== 1'b0) $display("FAIL drop_mark_dis got=%b exp=0", bus_l.marker_v_o); else passed++;
        drain_l();
    endtask

    task automatic test_async_reset();
        logic found = 1'b0;
        bus_s.en_i    = 1'b1;
        bus_s.valid_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus_s.marker_v_o === 1'b0 && bus_s.slot_cnt_o === 6'd40) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) $display("FAIL reach_cnt40 got=0 exp=1"); else passed++;
        #2 nreset = 1'b0;
        #1;
        total++; if (bus_s.marker_v_o !== 1'b0) $display("FAIL async_marker got=%b exp=0", bus_s.marker_v_o); else passed++;
        total++; if (bus_s.ready_o !== 1'b1) $display("FAIL async_ready got=%b exp=1", bus_s.ready_o); else passed++;
        total++; if (bus_s.bip_clr_o !== 1'b0) $display("FAIL async_bip got=%b exp=0", bus_s.bip_clr_o); else passed++;
        total++; if (bus_s.slot_cnt_o !== 6'd0) $display("FAIL async_cnt got=%0d exp=0", bus_s.slot_cnt_o); else passed++;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        total++; if (bus_s.marker_v_o !== 1'b1) $display("FAIL restart_marker got=%b exp=1", bus_s.marker_v_o); else passed++;
        drain_s();
    endtask

    task automatic test_random();
        int marks = 0;
        int bips = 0;
        int data_n = 0;
        int period_err = 0;
        int overlap = 0;
        int consec = 0;
        logic started = 1'b0;
        logic prev_m = 1'b0;
        logic prev_b = 1'b0;
        logic done = 1'b0;
        logic v;
        bus_s.en_i    = 1'b1;
        bus_s.valid_i = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus_s.marker_v_o === 1'b1 && bus_s.ready_o === 1'b1) overlap++;
            if (bus_s.bip_clr_o === 1'b1 && prev_b) consec++;
            if (bus_s.marker_v_o === 1'b1 && !prev_m) begin
                marks++;
                if (started && data_n != EFF_S - 1) period_err++;
            end
            if (bus_s.bip_clr_o === 1'b1) begin
                bips++;
                started = 1'b1;
                data_n  = 0;
            end
            prev_m = bus_s.marker_v_o;
            prev_b = bus_s.bip_clr_o;
            if (bips == 3) begin
                done = 1'b1;
                break;
            end
            v = ($urandom_range(0, 3) != 0);
            bus_s.valid_i = v;
            if (started && bus_s.ready_o === 1'b1 && v) data_n++;
        end
        total++; if (!done) $display("FAIL random_timeout got=0 exp=1"); else passed++;
        total++; if (marks != 3) $display("FAIL random_marks got=%0d exp=3", marks); else passed++;
        total++; if (bips != 3) $display("FAIL random_bips got=%0d exp=3", bips); else passed++;
        total++; if (overlap != 0) $display("FAIL marker_with_ready got=%0d exp=0", overlap); else passed++;
        total++; if (consec != 0) $display("FAIL bip_consecutive got=%0d exp=0", consec); else passed++;
        total++; if (period_err != 0) $display("FAIL random_period_len got=%0d exp=0", period_err); else passed++;
        drain_s();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_full_period();
        test_valid_toggle();
        test_en_drop_run();
        test_en_drop_mark();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
